// File: rtl/mpu_pkg.sv
// Shared MPU definitions: element/matrix geometry, index width and the
// result-streamer state encoding, reused by the MPU compute blocks.
package mpu_pkg;

    localparam int DATA_W = 8;   // element width in bits
    localparam int DIM    = 5;   // maximum matrix dimension
    localparam int IDX_W  = 3;   // row/column index width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/mpu_result_streamer.sv
// Captures an MPU result matrix on start and streams the active N_eff x N_eff
// block row-major over a valid/ready interface, then pulses done.
module mpu_result_streamer #(
    parameter int DATA_W = mpu_pkg::DATA_W,
    parameter int DIM    = mpu_pkg::DIM
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [7:0]                  size,
    input  logic [DIM*DIM*DATA_W-1:0]   matrix,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [2:0]                  out_row,
    output logic [2:0]                  out_col,
    output logic                        out_last,
    output logic                        done
);

    import mpu_pkg::*;

    localparam int         MAT_W = DIM * DIM * DATA_W;
    localparam logic [7:0] DIM_8 = 8'(DIM);

    state_t               state_reg;
    state_t               state_next;
    logic [MAT_W-1:0]     cap_matrix_reg;
    logic [7:0]           n_eff_reg;
    logic [IDX_W-1:0]     row_reg;
    logic [IDX_W-1:0]     col_reg;

    logic [7:0]           n_eff_clamped;
    logic [7:0]           last_idx;
    logic                 col_at_end;
    logic                 row_at_end;
    logic                 xfer;
    logic [DATA_W-1:0]    elem_sel;

    // Oversized requests are clamped to the physical matrix dimension.
    assign n_eff_clamped = (size > DIM_8) ? DIM_8 : size;
    assign last_idx      = n_eff_reg - 8'd1;
    assign col_at_end    = (8'(col_reg) == last_idx);
    assign row_at_end    = (8'(row_reg) == last_idx);
    assign xfer          = out_valid && out_ready;
    assign elem_sel      = cap_matrix_reg[(int'(row_reg) * DIM + int'(col_reg)) * DATA_W +: DATA_W];

    // Outputs are decoded from registered state so reset clears them at once;
    // the element fields are forced to zero whenever nothing is offered.
    assign out_valid = (state_reg == STREAM);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == FINISH);
    assign out_data  = out_valid ? elem_sel : '0;
    assign out_row   = out_valid ? 3'(row_reg) : 3'd0;
    assign out_col   = out_valid ? 3'(col_reg) : 3'd0;
    assign out_last  = out_valid && row_at_end && col_at_end;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode: an empty request skips straight to FINISH.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (size == 8'd0) ? FINISH : STREAM;
                end
            end
            STREAM: begin
                if (xfer && out_last) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture on start (only when idle) and walk row/col on each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_matrix_reg <= '0;
            n_eff_reg      <= '0;
            row_reg        <= '0;
            col_reg        <= '0;
        end else begin
            if (state_reg == IDLE && start) begin
                cap_matrix_reg <= matrix;
                n_eff_reg      <= n_eff_clamped;
                row_reg        <= '0;
                col_reg        <= '0;
            end else if (xfer) begin
                if (col_at_end) begin
                    col_reg <= '0;
                    row_reg <= row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
        end
    end

endmodule
